// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//
// Feeds the 7-segment decoders: each 4-bit digit of bcd drives one display.
// The last completed result stays on bcd/ovf between conversions.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    request a conversion (sampled only while idle)
//   bin      binary value, captured on the accepting edge
//   busy     high while a conversion is in progress
//   done     one-cycle pulse when bcd/ovf update
//   bcd      result, digit i in bits [4i+3:4i], digit 0 = ones
//   ovf      value did not fit in DIGITS decimal digits (held until next done)

module bin_to_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q;
  logic [WIDTH-1:0]    bin_q;
  logic [4*DIGITS-1:0] scratch_q;
  logic                ovf_s_q;
  logic [CntW-1:0]     cnt_q;

  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] scratch_nx;
  logic [WIDTH-1:0]    bin_nx;
  logic                shout;

  // One double-dabble iteration: add 3 to every digit >= 5 (no inter-digit
  // carry), then shift {scratch, binary} left by one. The bit leaving the top
  // digit is a multiple of 10^DIGITS and only matters as overflow.
  always_comb begin
    adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                     : scratch_q[4*i +: 4];
    end
    {shout, scratch_nx, bin_nx} = {adj, bin_q, 1'b0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      bin_q     <= '0;
      scratch_q <= '0;
      ovf_s_q   <= 1'b0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q     <= bin;
            scratch_q <= '0;
            ovf_s_q   <= 1'b0;
            cnt_q     <= CntW'(WIDTH);
            busy      <= 1'b1;
            state_q   <= StShift;
          end
        end
        StShift: begin
          bin_q     <= bin_nx;
          scratch_q <= scratch_nx;
          ovf_s_q   <= ovf_s_q | shout;
          cnt_q     <= cnt_q - CntW'(1);
          // Publish only from the final iteration; partial results never leave.
          if (cnt_q == CntW'(1)) begin
            bcd     <= scratch_nx;
            ovf     <= ovf_s_q | shout;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
`timescale 1ns / 1ps

module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start1, start2;
  logic [7:0]  bin1, bin2;
  logic        busy1, done1, ovf1;
  logic        busy2, done2, ovf2;
  logic [11:0] bcd1;
  logic [7:0]  bcd2;

  int n_vec = 0;
  int n_err = 0;

  // Expected {ovf, bcd} per conversion, pushed at start, popped on done.
  logic [12:0] q1[$];
  logic [12:0] q2[$];

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start1), .bin(bin1),
    .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
  );

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .ovf(ovf2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Decimal reference by repeated division.
  function automatic logic [12:0] model(input int v, input int digits);
    int x;
    logic [11:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < digits; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return {(x != 0), r};
  endfunction

  // Scoreboard side: compare on every done pulse.
  always @(negedge clk) begin
    logic [12:0] e;
    if (done1) begin
      if (q1.size() == 0) check("done1_spurious", 1, 0);
      else begin
        e = q1.pop_front();
        check("bcd1", 32'(bcd1), 32'(e[11:0]));
        check("ovf1", 32'(ovf1), 32'(e[12]));
        check("busy_at_done1", 32'(busy1), 0);
      end
    end
    if (done2) begin
      if (q2.size() == 0) check("done2_spurious", 1, 0);
      else begin
        e = q2.pop_front();
        check("bcd2", 32'(bcd2), 32'(e[7:0]));
        check("ovf2", 32'(ovf2), 32'(e[12]));
        check("busy_at_done2", 32'(busy2), 0);
      end
    end
  end

  // Call on a falling edge; returns on the falling edge where done is seen,
  // so the next call can start in the done cycle.
  task automatic conv(input int sel, input int v);
    int lat;
    int nbusy;
    if (sel == 1) begin
      start1 = 1'b1; bin1 = 8'(v); q1.push_back(model(v, 3));
    end else begin
      start2 = 1'b1; bin2 = 8'(v); q2.push_back(model(v, 2));
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
    lat = 1;
    nbusy = 0;
    while (lat < 40 && !((sel == 1) ? done1 : done2)) begin
      if ((sel == 1) ? busy1 : busy2) nbusy++;
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 9);
    check("busy_cycles", 32'(nbusy), 8);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    start1 = 1'b0; start2 = 1'b0;
    bin1 = '0; bin2 = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle1", 32'({busy1, done1, ovf1, bcd1}), 0);
      check("idle2", 32'({busy2, done2, ovf2, bcd2}), 0);
    end

    // Basic values.
    conv(1, 255);
    @(negedge clk);
    conv(1, 0);
    @(negedge clk);
    conv(1, 99);
    repeat (3) @(negedge clk);

    // Exhaustive, back-to-back: each start issued in the previous done cycle.
    for (int v = 0; v < 256; v++) conv(1, v);
    repeat (3) @(negedge clk);

    // Start while busy is ignored; old result held until done.
    start1 = 1'b1; bin1 = 8'd37; q1.push_back(model(37, 3));
    @(negedge clk);
    start1 = 1'b0;
    check("hold_c1", 32'(bcd1), 32'h255);
    for (int c = 2; c <= 5; c++) begin
      start1 = 1'b1; bin1 = 8'd200;
      @(negedge clk);
      check("hold_bcd", 32'(bcd1), 32'h255);
      check("hold_busy", 32'(busy1), 1);
    end
    start1 = 1'b0;
    repeat (20) @(negedge clk);
    check("q1_drained_37", 32'(q1.size()), 0);
    check("after_37", 32'(bcd1), 32'h037);

    // Asynchronous reset mid-conversion.
    start1 = 1'b1; bin1 = 8'd128;
    @(negedge clk);
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst", 32'({busy1, done1, ovf1, bcd1}), 0);
    repeat (3) @(negedge clk);
    check("in_rst", 32'({busy1, done1, ovf1, bcd1}), 0);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", 32'({busy1, bcd1}), 0);
    conv(1, 128);
    repeat (3) @(negedge clk);

    // Two-digit instance: overflow.
    conv(2, 100);
    @(negedge clk);
    conv(2, 99);
    @(negedge clk);
    conv(2, 255);
    repeat (5) @(negedge clk);

    check("q1_empty", 32'(q1.size()), 0);
    check("q2_empty", 32'(q2.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
